// File: rtl/arb_requester.sv
// Burst requester: asks an arbiter for a shared resource, moves len beats while
// granted, resumes after a lost grant, and aborts if the grant never arrives.
module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             gnt_i,
    output logic             req_o,
    output logic             xfer_valid_o,
    output logic [LEN_W-1:0] beat_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_q;
    logic [LEN_W-1:0] beat_d;
    logic [7:0]       wait_q;
    logic             req_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    assign beat_d = beat_q + {{(LEN_W-1){1'b0}}, 1'b1};

    // Burst sequencing; every output except xfer_valid is decoded into a register here
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= {LEN_W{1'b0}};
            beat_q  <= {LEN_W{1'b0}};
            wait_q  <= 8'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != {LEN_W{1'b0}}) begin
                            len_q   <= len_i;
                            beat_q  <= {LEN_W{1'b0}};
                            wait_q  <= 8'd0;
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (gnt_i) begin
                        state_q <= XFER;
                        wait_q  <= 8'd0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                XFER: begin
                    if (gnt_i) begin
                        beat_q <= beat_d;
                        if (beat_d == len_q) begin
                            state_q <= REL;
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        // Grant lost: keep progress, restart the timeout window
                        state_q <= REQ;
                        wait_q  <= 8'd0;
                    end
                end
                REL: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign xfer_valid_o = (state_q == XFER) && gnt_i;
    assign req_o        = req_q;
    assign beat_cnt_o   = beat_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_arb_requester.sv
// Randomized bench for arb_requester: a grant-stream reference model predicts each
// burst's outcome, and a monitor checks every done/err pulse against a queue.
module tb_arb_requester;

    localparam int LEN_W = 4;
    localparam int TMO   = 15;

    logic             clk_i;
    logic             rst_ni;
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             gnt_i;
    logic             req_o;
    logic             xfer_valid_o;
    logic [LEN_W-1:0] beat_cnt_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    arb_requester #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .len_i        (len_i),
        .gnt_i        (gnt_i),
        .req_o        (req_o),
        .xfer_valid_o (xfer_valid_o),
        .beat_cnt_o   (beat_cnt_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    typedef struct {
        bit is_err;
        int beats;
        int cyc;
        bit busy;
    } exp_t;

    exp_t exp_q[$];
    bit   gbuf[256];
    int   checks;
    int   errors;
    int   cyc;
    int   xv_cnt;
    int   last_beats;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Free-running cycle index: value k during the cycle after edge k
    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Outcome of a burst of n beats given grant stream gbuf[c] during cycle k+c.
    // A beat happens in any granted cycle that follows a granted cycle; only
    // ungranted cycles not directly after a granted one count toward the timeout.
    task automatic model(input int n, output bit is_err, output int beats, output int off);
        bit prev = 1'b0;
        int zeros = 0;
        beats = 0;
        off = -1;
        is_err = 1'b0;
        for (int c = 0; c < 256 && off < 0; c++) begin
            if (gbuf[c]) begin
                if (prev) begin
                    beats++;
                    if (beats == n) begin
                        off = c + 1;
                        is_err = 1'b0;
                    end
                end
                zeros = 0;
            end else if (!prev) begin
                zeros++;
                if (zeros == TMO) begin
                    off = c + 1;
                    is_err = 1'b1;
                end
            end
            prev = gbuf[c];
        end
        if (off < 0) off = 255;
    endtask

    // Scoreboard monitor: every done/err pulse must match the oldest prediction
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            xv_cnt = 0;
        end else begin
            if (xfer_valid_o) begin
                xv_cnt++;
                chk("req_during_beat", int'(req_o), 1);
            end
            if (done_o || err_o) begin
                chk("done_err_exclusive", int'(done_o && err_o), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got done=%0d err=%0d expected none (cycle %0d)",
                             done_o, err_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("err_flag", int'(err_o), int'(e.is_err));
                    chk("done_flag", int'(done_o), int'(!e.is_err));
                    chk("event_cycle", cyc, e.cyc);
                    chk("beat_cnt", int'(beat_cnt_o), e.beats);
                    chk("busy_at_event", int'(busy_o), int'(e.busy));
                    chk("req_at_event", int'(req_o), 0);
                    chk("xfer_valid_count", xv_cnt, e.beats == last_beats && e.busy == 1'b0
                        && !e.is_err ? 0 : e.beats);
                end
                xv_cnt = 0;
            end
        end
    end

    task automatic fill_grants(input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0: gbuf[i] = (i != 0);
                1: gbuf[i] = 1'b0;
                2: gbuf[i] = (i >= 200) ? 1'b1 : ($urandom_range(3, 0) != 0);
                3: gbuf[i] = !(i == 0 || i == 4 || i == 5);
                default: gbuf[i] = 1'b1;
            endcase
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk_i);
    endtask

    task automatic run_burst(input int n, input int mode, input bit extra_start);
        exp_t e;
        bit   is_err;
        int   beats;
        int   off;
        int   k;
        fill_grants(mode);
        if (n == 0) begin
            is_err = 1'b0;
            beats  = last_beats;
            off    = 0;
        end else begin
            model(n, is_err, beats, off);
        end
        @(negedge clk_i);
        start_i = 1'b1;
        len_i   = LEN_W'(n);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        k = cyc;
        e.is_err = is_err;
        e.beats  = beats;
        e.cyc    = k + off;
        e.busy   = (n != 0) && !is_err;
        exp_q.push_back(e);
        last_beats = beats;
        if (n != 0) begin
            for (int i = 0; i < off; i++) begin
                gnt_i = gbuf[i];
                if (extra_start && i == 1) begin
                    start_i = 1'b1;
                    len_i   = 4'd5;
                end else begin
                    start_i = 1'b0;
                end
                @(posedge clk_i);
                #1;
            end
        end
        gnt_i   = 1'b0;
        start_i = 1'b0;
        wait_drain();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        xv_cnt     = 0;
        last_beats = 0;
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        len_i      = '0;
        gnt_i      = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_req", int'(req_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_beat", int'(beat_cnt_o), 0);
        chk("rst_xfer", int'(xfer_valid_o), 0);
        rst_ni = 1'b1;

        run_burst(3, 0, 1'b0);
        run_burst(4, 3, 1'b0);
        run_burst(5, 1, 1'b0);
        run_burst(0, 0, 1'b0);
        run_burst(2, 0, 1'b1);
        run_burst(15, 0, 1'b0);

        // Reset mid-transfer after the second beat of a six-beat burst
        fill_grants(0);
        @(negedge clk_i);
        start_i = 1'b1;
        len_i   = 4'd6;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gnt_i = gbuf[i];
            @(posedge clk_i);
            #1;
        end
        chk("pre_rst_beat", int'(beat_cnt_o), 2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_req", int'(req_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_beat", int'(beat_cnt_o), 0);
        chk("midrst_xfer", int'(xfer_valid_o), 0);
        gnt_i = 1'b0;
        last_beats = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_burst(1, 0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            run_burst($urandom_range(15, 0),
                      ($urandom_range(5, 0) == 0) ? 1 : int'($urandom_range(2, 0) == 0 ? 0 : 2),
                      $urandom_range(1, 0) == 1);
        end

        repeat (5) @(negedge clk_i);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter LEN_W, default 4, SHALL set the width of the burst-length input and beat counter.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of consecutive cycles spent in REQ without a grant before abort (1..255).
REQ-003 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle burst command, sampled only in IDLE.
REQ-006 len  input  LEN_W  SHALL be the number of beats requested, sampled with start.
REQ-007 gnt  input  1  SHALL be the grant from the arbiter, sampled every rising edge.
REQ-008 req  output  1  SHALL request the shared resource toward the arbiter.
REQ-009 xfer_valid  output  1  SHALL mark a beat transferred in the current cycle.
REQ-010 beat_cnt  output  LEN_W  SHALL give the number of beats completed in the current burst.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 done  output  1  SHALL pulse for one cycle when a burst completes.
REQ-013 err  output  1  SHALL pulse for one cycle when a burst aborts on timeout.

Function
REQ-014 The FSM SHALL have four states: IDLE, REQ, XFER, REL.
REQ-015 IDLE: start=1 and len!=0 -> latch len, clear beat_cnt and wait counter, go to REQ.
REQ-016 IDLE: start=1 and len==0 -> stay in IDLE and assert done for the next cycle; req stays 0.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 req SHALL be 1 in REQ and XFER, and 0 in IDLE and REL (registered, state-decoded).
REQ-019 REQ: gnt=1 -> go to XFER and clear the wait counter; gnt=0 -> increment the wait counter.
REQ-020 REQ: gnt=0 with wait counter == TIMEOUT-1 -> go to IDLE, pulse err for one cycle, leave beat_cnt unchanged.
REQ-021 xfer_valid SHALL equal (state==XFER) AND gnt, decoded combinationally.
REQ-022 XFER: each cycle with xfer_valid=1 SHALL increment beat_cnt by 1 at the closing edge.
REQ-023 XFER: a beat that makes beat_cnt equal to the latched len -> go to REL.
REQ-024 XFER: gnt=0 (grant lost) -> go to REQ; beat_cnt is preserved, the wait counter restarts at 0, and the burst resumes on re-grant.
REQ-025 REL SHALL last exactly one cycle: req=0, done=1, then go to IDLE.
REQ-026 beat_cnt SHALL hold its final value in IDLE until the next accepted start.
REQ-027 Latency, with the arbiter granting on the first edge after req rises:
  - start sampled at edge k -> req=1 from edge k
  - gnt=1 from edge k+1
  - state XFER and first beat in cycle k+2
  - for len=N, done=1 in cycle k+2+N
REQ-028 len equal to the maximum value (2^LEN_W-1) SHALL complete with no counter wrap.
REQ-029 done and err SHALL never be asserted in the same cycle.

Reset
REQ-030 While reset=0, the block SHALL enter IDLE immediately, regardless of the clock.
REQ-031 While reset=0, the outputs SHALL be req=0, busy=0, done=0, err=0, beat_cnt=0, xfer_valid=0.
REQ-032 A reset asserted mid-burst SHALL abandon the burst without asserting done or err.
REQ-033 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-034 len=3, gnt held 1 from one cycle after req rises -> xfer_valid high for 3 cycles, beat_cnt goes 1,2,3, one done pulse, req drops in the REL cycle.
REQ-035 len=4, gnt dropped for 2 cycles after beat 2 -> state returns to REQ; beat_cnt holds 2; after re-grant, beats 3 and 4 complete; one done pulse.
REQ-036 TIMEOUT=15, len=5, gnt held 0 -> err pulse exactly 15 cycles after req rises; req=0 and busy=0 in the next cycle; done never asserted.
REQ-037 start with len=0 -> done pulse in the next cycle; req, busy and xfer_valid stay 0.
REQ-038 reset driven low mid-XFER at beat 2 of len=6 (between clock edges) -> req, busy and beat_cnt are 0 at once; no done; a new start of len=1 after release completes normally.
REQ-039 start pulsed again while busy with len=2 -> ignored; exactly 2 beats and one done.
